// File: rtl/des_pkg.sv
// DES constants (permutation tables, S-boxes, key shift schedule) and the
// bit-level helpers shared by the round datapath and the core controller.
package des_pkg;

  localparam int DES_BLOCK_W = 64;
  localparam int DES_KEY_W   = 56;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} des_state_e;

  // Table entries use FIPS 46 numbering: bit 1 is the MSB of the input word.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Indexed by {box[2:0], row[1:0], col[3:0]}.
  localparam int SBOX [512] = '{
    14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
    0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
    4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
    15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
    15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
    3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
    0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
    13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
    10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
    13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
    1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
    7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
    13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
    10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
    3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
    2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
    14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
    4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
    11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
    12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
    10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
    9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
    4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
    4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
    13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
    1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
    6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
    13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
    1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
    7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
    2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[6'(63 - i)] = x[6'(64 - IP_T[i])];
    return r;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[6'(63 - i)] = x[6'(64 - FP_T[i])];
    return r;
  endfunction

  function automatic logic [47:0] expand_e(input logic [31:0] x);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[6'(47 - i)] = x[5'(32 - E_T[i])];
    return r;
  endfunction

  function automatic logic [31:0] perm_p(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[5'(31 - i)] = x[5'(32 - P_T[i])];
    return r;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] r;
    for (int i = 0; i < 56; i++) r[6'(55 - i)] = x[6'(64 - PC1_T[i])];
    return r;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[6'(47 - i)] = x[6'(56 - PC2_T[i])];
    return r;
  endfunction

  // Row comes from the outer two bits of each 6-bit group, column from the inner four.
  function automatic logic [31:0] sbox_sub(input logic [47:0] x);
    logic [31:0] r;
    logic [5:0]  six;
    r = '0;
    for (int s = 0; s < 8; s++) begin
      six = x[6'(42 - 6 * s) +: 6];
      r[5'(28 - 4 * s) +: 4] = 4'(SBOX[{s[2:0], six[5], six[0], six[4:1]}]);
    end
    return r;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
    case (n)
      1:       return {x[26:0], x[27]};
      2:       return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
    case (n)
      1:       return {x[0], x[27:1]};
      2:       return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES Feistel round: expansion, subkey mix, S-boxes, P.
module des_round
  import des_pkg::*;
(
  input  logic [31:0] blk_l,
  input  logic [31:0] blk_r,
  input  logic [47:0] subkey,
  output logic [31:0] nxt_l,
  output logic [31:0] nxt_r
);

  assign nxt_l = blk_r;
  assign nxt_r = blk_l ^ perm_p(sbox_sub(expand_e(blk_r) ^ subkey));

endmodule

// File: rtl/des_chain_core.sv
// Iterative DES engine with optional CBC chaining and key parity checking;
// ROUNDS_PER_CYCLE rounds are unrolled per clock with subkeys derived on the fly.
module des_chain_core
  import des_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int CHAIN_EN         = 1,
  parameter int PARITY_CHECK     = 1
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [DES_BLOCK_W-1:0] data_in,
  input  logic [DES_BLOCK_W-1:0] key_in,
  input  logic [DES_BLOCK_W-1:0] iv_in,
  input  logic                   iv_load_in,
  input  logic                   mode_in,
  input  logic                   chain_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DES_BLOCK_W-1:0] data_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   err_out,
  output logic [1:0]             state_dbg
);

  localparam int RUN_CYCLES = 16 / ROUNDS_PER_CYCLE;

  des_state_e             state_q;
  logic [3:0]             cnt_q;
  logic [31:0]            l_q, r_q;
  logic [27:0]            c_q, d_q;
  logic                   mode_q, cbc_q, err_q;
  logic [DES_BLOCK_W-1:0] cv_q, din_q, chain_q, data_q;

  logic                   accept, chain_sel, par_err, last_cyc;
  logic [7:0]             byte_par;
  logic [DES_BLOCK_W-1:0] chain_val, blk_pre, ip_blk, des_res, result;
  logic [DES_KEY_W-1:0]   kpc1;

  logic [31:0] l_s [ROUNDS_PER_CYCLE+1];
  logic [31:0] r_s [ROUNDS_PER_CYCLE+1];
  logic [27:0] c_s [ROUNDS_PER_CYCLE+1];
  logic [27:0] d_s [ROUNDS_PER_CYCLE+1];

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign data_out  = data_q;
  assign err_out   = err_q;
  assign state_dbg = state_q;

  always_comb begin
    byte_par = '0;
    for (int i = 0; i < 8; i++) byte_par[i] = ^key_in[6'(8 * i) +: 8];
  end

  assign par_err   = (PARITY_CHECK != 0) & ~(&byte_par);
  assign chain_sel = (CHAIN_EN != 0) & chain_in;
  assign chain_val = iv_load_in ? iv_in : chain_q;
  // CBC encrypt whitens the plaintext before IP; decrypt unwhitens after FP.
  assign blk_pre   = data_in ^ ((chain_sel & ~mode_in) ? chain_val : '0);
  assign ip_blk    = perm_ip(blk_pre);
  assign kpc1      = perm_pc1(key_in);

  assign l_s[0] = l_q;
  assign r_s[0] = r_q;
  assign c_s[0] = c_q;
  assign d_s[0] = d_q;

  for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_rnd
    logic [3:0]  rnd, rev;
    logic [27:0] c_n, d_n;
    logic [47:0] subkey;

    assign rnd = cnt_q * 4'(ROUNDS_PER_CYCLE) + 4'(g);
    assign rev = 4'd0 - rnd;

    // Decrypt starts from C16/D16 == C0/D0, then walks the schedule backwards.
    always_comb begin
      c_n = c_s[g];
      d_n = d_s[g];
      if (mode_q) begin
        if (rnd != 4'd0) begin
          c_n = rotr28(c_s[g], SHIFTS[rev]);
          d_n = rotr28(d_s[g], SHIFTS[rev]);
        end
      end else begin
        c_n = rotl28(c_s[g], SHIFTS[rnd]);
        d_n = rotl28(d_s[g], SHIFTS[rnd]);
      end
    end

    assign c_s[g+1] = c_n;
    assign d_s[g+1] = d_n;
    assign subkey   = perm_pc2({c_n, d_n});

    des_round u_round (
      .blk_l  (l_s[g]),
      .blk_r  (r_s[g]),
      .subkey (subkey),
      .nxt_l  (l_s[g+1]),
      .nxt_r  (r_s[g+1])
    );
  end

  assign last_cyc = (cnt_q == 4'(RUN_CYCLES - 1));
  assign des_res  = perm_fp({r_s[ROUNDS_PER_CYCLE], l_s[ROUNDS_PER_CYCLE]});
  assign result   = des_res ^ ((cbc_q & mode_q) ? cv_q : '0);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      chain_q <= '0;
    end else begin
      case (state_q)
        RUN: begin
          l_q <= l_s[ROUNDS_PER_CYCLE];
          r_q <= r_s[ROUNDS_PER_CYCLE];
          c_q <= c_s[ROUNDS_PER_CYCLE];
          d_q <= d_s[ROUNDS_PER_CYCLE];
          if (last_cyc) begin
            state_q <= DONE;
            cnt_q   <= '0;
            data_q  <= result;
            err_q   <= 1'b0;
            if (cbc_q) chain_q <= mode_q ? din_q : des_res;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
            data_q  <= '0;
            err_q   <= 1'b0;
          end
        end
        default: ;
      endcase

      // A new block overrides the DONE->IDLE exit above when it is accepted.
      if (accept) begin
        mode_q <= mode_in;
        cbc_q  <= chain_sel;
        cv_q   <= chain_val;
        din_q  <= data_in;
        l_q    <= ip_blk[63:32];
        r_q    <= ip_blk[31:0];
        c_q    <= kpc1[55:28];
        d_q    <= kpc1[27:0];
        cnt_q  <= '0;
        if (par_err) begin
          state_q <= DONE;
          data_q  <= '0;
          err_q   <= 1'b1;
        end else begin
          state_q <= RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_des_chain_core.sv
// Directed bench for des_chain_core: ECB/CBC vectors, parity error, backpressure
// and mid-block reset on a 1-round core, plus latency/decrypt on a 4-round core.
module tb_des_chain_core;

  localparam logic [63:0] K_GOOD = 64'h133457799BBCDFF1;
  localparam logic [63:0] K_BAD  = 64'h123457799BBCDFF1;
  localparam logic [63:0] P1     = 64'h0123456789ABCDEF;
  localparam logic [63:0] C1     = 64'h85E813540F0AB405;
  localparam logic [63:0] P2     = 64'h84CB563386A179EA;
  localparam logic [63:0] P3     = 64'h0011223344556677;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] data_in = '0, key_in = '0, iv_in = '0;
  logic        iv_load = 1'b0, mode = 1'b0, chain = 1'b0;
  logic        in_valid1 = 1'b0, in_valid4 = 1'b0, out_ready = 1'b1;
  logic        sel4 = 1'b0;

  logic        in_ready1, out_valid1, err1, in_ready4, out_valid4, err4;
  logic [63:0] data_out1, data_out4;
  logic [1:0]  st1, st4;

  logic        cur_in_ready, cur_out_valid, cur_err;
  logic [63:0] cur_data_out;

  int n_checks = 0, n_pass = 0, n_fail = 0;
  logic [63:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  des_chain_core #(.ROUNDS_PER_CYCLE(1)) dut1 (
    .clk_in(clk), .rst_in(rst), .data_in(data_in), .key_in(key_in), .iv_in(iv_in),
    .iv_load_in(iv_load), .mode_in(mode), .chain_in(chain), .in_valid(in_valid1),
    .in_ready(in_ready1), .data_out(data_out1), .out_valid(out_valid1),
    .out_ready(out_ready), .err_out(err1), .state_dbg(st1));

  des_chain_core #(.ROUNDS_PER_CYCLE(4)) dut4 (
    .clk_in(clk), .rst_in(rst), .data_in(data_in), .key_in(key_in), .iv_in(iv_in),
    .iv_load_in(iv_load), .mode_in(mode), .chain_in(chain), .in_valid(in_valid4),
    .in_ready(in_ready4), .data_out(data_out4), .out_valid(out_valid4),
    .out_ready(out_ready), .err_out(err4), .state_dbg(st4));

  assign cur_in_ready  = sel4 ? in_ready4  : in_ready1;
  assign cur_out_valid = sel4 ? out_valid4 : out_valid1;
  assign cur_err       = sel4 ? err4       : err1;
  assign cur_data_out  = sel4 ? data_out4  : data_out1;

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkint(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs == exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver: present one block, wait for its result, consume it
  task automatic run_block(input string tag, input logic [63:0] d, input logic [63:0] k,
                           input logic [63:0] v, input logic ld, input logic md,
                           input logic ch, input logic chk_d, input logic [63:0] exp_res,
                           input logic exp_err, input int exp_lat, output logic [63:0] got);
    int lat;
    logic [63:0] e;
    exp_q.push_back(exp_res);
    chkint({tag, " in_ready"}, int'(cur_in_ready), 1);
    data_in = d; key_in = k; iv_in = v; iv_load = ld; mode = md; chain = ch;
    if (sel4) in_valid4 = 1'b1; else in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0; in_valid4 = 1'b0;
    lat = 1;
    while (!cur_out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    e = exp_q.pop_front();
    chkint({tag, " latency"}, lat, exp_lat);
    if (chk_d) chk64({tag, " data"}, cur_data_out, e);
    chkint({tag, " err"}, int'(cur_err), int'(exp_err));
    got = cur_data_out;
    @(posedge clk); #1;
    chkint({tag, " consumed"}, int'(cur_out_valid), 0);
    chk64({tag, " data idle"}, cur_data_out, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] got, c3;
    logic        saw;
    int          lat;

    // reset state, sampled while reset is held
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chkint("rst in_ready", int'(in_ready1), 1);
    chkint("rst out_valid", int'(out_valid1), 0);
    chk64("rst data_out", data_out1, 64'h0);
    chkint("rst err", int'(err1), 0);
    chkint("rst state", int'(st1), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ECB, one round per cycle
    run_block("ecb enc r1", P1, K_GOOD, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, C1, 1'b0, 17, got);
    run_block("ecb dec r1", C1, K_GOOD, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1, P1, 1'b0, 17, got);

    // ECB, four rounds per cycle
    sel4 = 1'b1;
    run_block("ecb dec r4", C1, K_GOOD, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1, P1, 1'b0, 5, got);
    run_block("ecb enc r4", P1, K_GOOD, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, C1, 1'b0, 5, got);
    sel4 = 1'b0;

    // CBC encrypt with a parity-error block in the middle; chain must survive it
    run_block("cbc enc b1", P1, K_GOOD, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, C1, 1'b0, 17, got);
    run_block("parity err", P2, K_BAD, 64'h0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0, 1'b1, 1, got);
    run_block("cbc enc b2", P2, K_GOOD, 64'h0, 1'b0, 1'b0, 1'b1, 1'b1, C1, 1'b0, 17, got);
    run_block("cbc enc b3", P3, K_GOOD, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 17, c3);

    // CBC decrypt round trip, with an ECB block that must not disturb the chain
    run_block("cbc dec b1", C1, K_GOOD, 64'h0, 1'b1, 1'b1, 1'b1, 1'b1, P1, 1'b0, 17, got);
    run_block("ecb mid", P1, K_GOOD, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, C1, 1'b0, 17, got);
    run_block("cbc dec b2", C1, K_GOOD, 64'h0, 1'b0, 1'b1, 1'b1, 1'b1, P2, 1'b0, 17, got);
    run_block("cbc dec b3", c3, K_GOOD, 64'h0, 1'b0, 1'b1, 1'b1, 1'b1, P3, 1'b0, 17, got);

    // backpressure: hold the result, then release with a same-cycle accept
    out_ready = 1'b0;
    exp_q.push_back(C1);
    data_in = P1; key_in = K_GOOD; iv_load = 1'b0; mode = 1'b0; chain = 1'b0;
    in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    lat = 1;
    while (!out_valid1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chkint("bp latency", lat, 17);
    got = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk64("bp held data", data_out1, got);
      chkint("bp held valid", int'(out_valid1), 1);
      chkint("bp in_ready low", int'(in_ready1), 0);
    end
    chkint("bp state done", int'(st1), 2);
    exp_q.push_back(P1);
    data_in = C1; mode = 1'b1;
    out_ready = 1'b1; in_valid1 = 1'b1;
    #1;
    chkint("bp in_ready rel", int'(in_ready1), 1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    chkint("bp state run", int'(st1), 1);
    chkint("bp valid drop", int'(out_valid1), 0);
    lat = 1;
    while (!out_valid1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chkint("bp2 latency", lat, 17);
    chk64("bp2 data", data_out1, exp_q.pop_front());
    @(posedge clk); #1;

    // reset in cycle 8 of RUN aborts the block
    data_in = P1; key_in = K_GOOD; mode = 1'b0; chain = 1'b0;
    in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chkint("mid rst state", int'(st1), 0);
    chkint("mid rst in_ready", int'(in_ready1), 1);
    saw = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      saw = saw | out_valid1;
    end
    chkint("mid rst no valid", int'(saw), 0);
    run_block("post rst ecb", P1, K_GOOD, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, C1, 1'b0, 17, got);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/des_chain_core.md
DES_CHAIN_CORE -- requirements
Module: des_chain_core

Interface
REQ-001 SHALL have parameter ROUNDS_PER_CYCLE, default 1, Feistel rounds per clock; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have parameter CHAIN_EN, default 1, where 1 builds CBC support and 0 forces ECB.
REQ-003 SHALL have parameter PARITY_CHECK, default 1, where 1 enforces odd key-byte parity.
REQ-004 SHALL have port clk_in, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port data_in, input, 64 bits: plaintext or ciphertext block.
REQ-007 SHALL have port key_in, input, 64 bits: key including parity bits 0,8,...,56 (LSB of each byte).
REQ-008 SHALL have port iv_in, input, 64 bits: CBC initial vector.
REQ-009 SHALL have port iv_load_in, input, 1 bit: load iv_in into the chain register with this block.
REQ-010 SHALL have port mode_in, input, 1 bit: 0 encrypts, 1 decrypts.
REQ-011 SHALL have port chain_in, input, 1 bit: 0 selects ECB, 1 selects CBC (ignored when CHAIN_EN=0).
REQ-012 SHALL have port in_valid, input, 1 bit: input block valid.
REQ-013 SHALL have port in_ready, output, 1 bit: core can accept a block.
REQ-014 SHALL have port data_out, output, 64 bits: result block.
REQ-015 SHALL have port out_valid, output, 1 bit: data_out and err_out valid.
REQ-016 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-017 SHALL have port err_out, output, 1 bit: the current result carries a key parity error.

Function
REQ-018 SHALL implement FSM states IDLE, RUN and DONE.
- IDLE to RUN on accept.
- RUN to DONE after 16/ROUNDS_PER_CYCLE cycles.
- DONE to IDLE on out_ready, or DONE to RUN on out_ready with a simultaneous accept.
REQ-019 SHALL drive in_ready = (state==IDLE) | (state==DONE & out_ready), and SHALL define accept as in_valid & in_ready.
REQ-020 On accept, SHALL register mode, chain, key C/D halves (after PC-1) and the post-IP block; all inputs are ignored at any other time.
REQ-021 SHALL generate subkeys on the fly.
- Encrypt: rotate C/D left per the standard shift schedule.
- Decrypt: no rotate before round 1, then rotate right per the reversed schedule.
REQ-022 For a block accepted at edge T, out_valid SHALL rise in cycle T+16/ROUNDS_PER_CYCLE+1.
REQ-023 SHALL hold data_out and err_out stable while out_valid=1 and out_ready=0.
REQ-024 SHALL apply CBC encrypt as: block = data_in XOR chain before IP; chain <= result.
REQ-025 SHALL apply CBC decrypt as: result = DES^-1(data_in) XOR chain; chain <= data_in.
REQ-026 When iv_load_in=1 on accept, SHALL use iv_in as the chain value for that block.
REQ-027 SHALL leave the chain register unchanged in ECB mode.
REQ-028 On a parity error (PARITY_CHECK=1 and any key byte with even parity), SHALL accept the block, skip RUN, enter DONE next cycle with data_out=0 and err_out=1, and leave chain unchanged.
REQ-029 SHALL drive data_out to 0 whenever out_valid=0.

Reset
REQ-030 While rst_in=1 at a clock edge, SHALL force state IDLE, in_ready=1, out_valid=0, data_out=0, err_out=0, chain=0 and round counter=0.
REQ-031 Reset during RUN or DONE SHALL abort the block and discard the pending result.

Structure
REQ-032 SHALL place in package des_pkg:
- IP, FP, E, P, PC-1 and PC-2 tables
- S-boxes
- shift schedule
- state enum
- DES_BLOCK_W=64 and DES_KEY_W=56
REQ-033 SHALL instantiate sub-module des_round (one combinational Feistel round: E, key XOR, S-boxes, P) ROUNDS_PER_CYCLE times in a chain.

Verification
REQ-034 A bench SHALL check ECB encrypt: key 133457799BBCDFF1, data 0123456789ABCDEF, ROUNDS_PER_CYCLE=1 -> data_out 85E813540F0AB405 with out_valid 17 cycles after accept.
REQ-035 A bench SHALL check ECB decrypt: same key, data 85E813540F0AB405 -> 0123456789ABCDEF; repeat with ROUNDS_PER_CYCLE=4 -> latency 5.
REQ-036 A bench SHALL check parity error: key 123457799BBCDFF1 -> err_out=1 and data_out=0 one cycle after accept, chain unchanged.
REQ-037 A bench SHALL check the CBC round trip:
- Encrypt 3 blocks with iv_load_in=1 and iv 0 on the first block; block 1 -> 85E813540F0AB405.
- Decrypt the 3 ciphertexts with the same IV -> original plaintexts.
REQ-038 A bench SHALL check backpressure: out_ready=0 for 5 cycles -> data_out held, in_ready=0; then out_ready=1 with in_valid=1 -> same-cycle accept, no bubble.
REQ-039 A bench SHALL check mid-RUN reset: rst_in=1 in cycle 8 of RUN -> out_valid never asserts for that block, next block gives the correct ECB result.
